// File: rtl/dfr_input_mask_if.sv
// Handshake, mask-config and output bundle of the DFR input-masking stage.
// master: drives samples and mask writes (upstream/config side).
// slave:  the masking stage itself.
interface dfr_input_mask_if #(
    parameter int VIRTUAL_NODES  = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 16,
    parameter int NODE_IDX_WIDTH = $clog2(VIRTUAL_NODES)
);
    // Mask configuration write port
    logic                         mask_wen;
    logic [NODE_IDX_WIDTH-1:0]    mask_addr;
    logic signed [MASK_WIDTH-1:0] mask_din;

    // Sample input handshake
    logic                         sample_valid;
    logic                         sample_ready;
    logic signed [DATA_WIDTH-1:0] sample_data;

    // Masked node stream towards the reservoir
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         dout_valid;
    logic [NODE_IDX_WIDTH-1:0]    node_idx;
    logic                         sample_done;
    logic [31:0]                  sample_count;

    modport master (
        output mask_wen, mask_addr, mask_din,
        output sample_valid, sample_data,
        input  sample_ready,
        input  dout, dout_valid, node_idx, sample_done, sample_count
    );

    modport slave (
        input  mask_wen, mask_addr, mask_din,
        input  sample_valid, sample_data,
        output sample_ready,
        output dout, dout_valid, node_idx, sample_done, sample_count
    );
endinterface

// File: rtl/dfr_input_mask.sv
// DFR input-masking stage. Each accepted scalar sample is replayed over
// VIRTUAL_NODES consecutive cycles, scaled by a per-node Q(MASK_FRAC_BITS)
// mask coefficient, floored and saturated to DATA_WIDTH. A new sample can be
// taken on the last node cycle, so back-to-back samples stream without gaps.
module dfr_input_mask #(
    parameter int VIRTUAL_NODES  = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 16,
    parameter int MASK_FRAC_BITS = 14
) (
    input logic             clk,
    input logic             rst,
    dfr_input_mask_if.slave bus
);
    localparam int NODE_IDX_WIDTH = $clog2(VIRTUAL_NODES);
    localparam int PROD_WIDTH     = DATA_WIDTH + MASK_WIDTH;

    localparam logic [NODE_IDX_WIDTH-1:0] LAST_NODE = NODE_IDX_WIDTH'(VIRTUAL_NODES - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         sample_ready_c;
    logic                         accept;
    logic                         last_node;

    logic signed [DATA_WIDTH-1:0] sample_reg;
    logic [NODE_IDX_WIDTH-1:0]    node_cnt;
    logic signed [MASK_WIDTH-1:0] mask_mem [VIRTUAL_NODES];
    logic signed [MASK_WIDTH-1:0] mask_rd;

    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] shifted;
    logic signed [DATA_WIDTH-1:0] masked;

    assign last_node        = (node_cnt == LAST_NODE);
    assign accept           = bus.sample_valid && sample_ready_c;
    assign bus.sample_ready = sample_ready_c;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state and ready decode: idle always ready, emitting only on the last node.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        state_next     = state;
        sample_ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                sample_ready_c = 1'b1;
                if (bus.sample_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                sample_ready_c = last_node;
                if (last_node) begin
                    state_next = bus.sample_valid ? EMIT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample latch and node counter; counter parks on the last node when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg <= '0;
            node_cnt   <= '0;
        end else if (accept) begin
            sample_reg <= bus.sample_data;
            node_cnt   <= '0;
        end else if (state == EMIT && !last_node) begin
            node_cnt   <= node_cnt + NODE_IDX_WIDTH'(1);
        end
    end

    // Mask table write port; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the mask table is built from flops, not a RAM macro, because
            // reset must clear every coefficient; a RAM could not be reset here.
            mask_mem <= '{default: '0};
        end else if (bus.mask_wen && (32'(bus.mask_addr) < VIRTUAL_NODES)) begin
            mask_mem[bus.mask_addr] <= bus.mask_din;
        end
    end

    // Read returns the pre-write value in the write cycle, since the table is registered.
    assign mask_rd = mask_mem[node_cnt];

    // Full-width product, floor shift, saturate to the output range.
    always_comb begin
        product = PROD_WIDTH'(sample_reg) * PROD_WIDTH'(mask_rd);
        shifted = product >>> MASK_FRAC_BITS;
        masked  = shifted[DATA_WIDTH-1:0];
        if (!((&shifted[PROD_WIDTH-1:DATA_WIDTH-1]) || !(|shifted[PROD_WIDTH-1:DATA_WIDTH-1]))) begin
            masked = shifted[PROD_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Output register: one beat per EMIT cycle, dout/node_idx hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout        <= '0;
            bus.dout_valid  <= 1'b0;
            bus.node_idx    <= '0;
            bus.sample_done <= 1'b0;
        end else begin
            bus.dout_valid  <= (state == EMIT);
            bus.sample_done <= (state == EMIT) && last_node;
            if (state == EMIT) begin
                bus.dout     <= masked;
                bus.node_idx <= node_cnt;
            end
        end
    end

    // Accepted-sample counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sample_count <= '0;
        end else if (accept) begin
            bus.sample_count <= bus.sample_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_dfr_input_mask.sv
// Bench for dfr_input_mask: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model (a queue of pending node
// beats, each evaluated with integer arithmetic when it is due).
module tb_dfr_input_mask;
    localparam int VN  = 10;
    localparam int DW  = 32;
    localparam int MW  = 16;
    localparam int NIW = $clog2(VN);

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dfr_input_mask_if #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    dfr_input_mask #(
        .VIRTUAL_NODES (VN),
        .DATA_WIDTH    (DW),
        .MASK_WIDTH    (MW),
        .MASK_FRAC_BITS(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference arithmetic: exact product, floor divide by 2^14, clamp to 32-bit signed.
    function automatic longint model_beat(input longint s, input longint m);
        longint p;
        longint f;
        p = s * m;
        f = p / 16384;
        if ((p % 16384) != 0 && p < 0) f = f - 1;
        if (f > 64'sd2147483647) f = 64'sd2147483647;
        else if (f < -64'sd2147483648) f = -64'sd2147483648;
        return f;
    endfunction

    typedef struct {
        longint sample;
        int     node;
    } beat_t;

    beat_t  pending[$];
    longint tb_mask [VN];
    longint obs_dout[VN];
    longint exp_count   = 0;
    bit     cur_valid   = 0;
    int     cur_node    = 0;
    longint cur_dout    = 0;
    longint last_dout   = 0;
    int     run_len     = 0;
    int     longest_run = 0;

    // Model update at the rising edge, comparison at the falling edge.
    initial begin
        bit    rdy;
        beat_t b;
        foreach (tb_mask[i]) tb_mask[i] = 0;
        foreach (obs_dout[i]) obs_dout[i] = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                rdy       = (pending.size() <= 1);
                cur_valid = 0;
                if (pending.size() > 0) begin
                    b         = pending.pop_front();
                    cur_valid = 1;
                    cur_node  = b.node;
                    cur_dout  = model_beat(b.sample, tb_mask[b.node]);
                end
                if (bus.mask_wen && int'(bus.mask_addr) < VN)
                    tb_mask[bus.mask_addr] = longint'(bus.mask_din);
                if (bus.sample_valid && rdy) begin
                    for (int k = 0; k < VN; k++) begin
                        b.sample = longint'(bus.sample_data);
                        b.node   = k;
                        pending.push_back(b);
                    end
                    exp_count = (exp_count + 1) & 64'hFFFF_FFFF;
                end
            end
            @(negedge clk);
            if (rst) begin
                check("rst_dout", bus.dout, 0);
                check("rst_dout_valid", bus.dout_valid, 0);
                check("rst_node_idx", bus.node_idx, 0);
                check("rst_sample_done", bus.sample_done, 0);
                check("rst_sample_count", bus.sample_count, 0);
                check("rst_sample_ready", bus.sample_ready, 1);
                pending.delete();
                foreach (tb_mask[i]) tb_mask[i] = 0;
                foreach (obs_dout[i]) obs_dout[i] = 0;
                exp_count   = 0;
                cur_valid   = 0;
                last_dout   = 0;
                run_len     = 0;
                longest_run = 0;
            end else begin
                check("dout_valid", bus.dout_valid, cur_valid);
                if (cur_valid) begin
                    check("dout", bus.dout, cur_dout);
                    check("node_idx", bus.node_idx, cur_node);
                    check("sample_done", bus.sample_done, cur_node == VN - 1);
                    obs_dout[cur_node] = bus.dout;
                    last_dout = cur_dout;
                    run_len++;
                    if (run_len > longest_run) longest_run = run_len;
                end else begin
                    check("dout_hold", bus.dout, last_dout);
                    check("sample_done_idle", bus.sample_done, 0);
                    run_len = 0;
                end
                check("sample_ready", bus.sample_ready, pending.size() <= 1);
                check("sample_count", bus.sample_count, exp_count);
            end
        end
    end

    // Drive every input for one cycle, just after the falling edge.
    task automatic drive(input bit v, input longint d, input bit wen, input int addr, input longint din);
        @(negedge clk);
        #1;
        bus.sample_valid = v;
        bus.sample_data  = DW'(d);
        bus.mask_wen     = wen;
        bus.mask_addr    = NIW'(addr);
        bus.mask_din     = MW'(din);
    endtask

    task automatic write_mask(input int addr, input longint val);
        drive(0, 0, 1, addr, val);
    endtask

    // Offer a sample and return once the next rising edge is guaranteed to accept it.
    task automatic send_sample(input longint d);
        int waited;
        drive(1, d, 0, 0, 0);
        waited = 0;
        while (!bus.sample_ready && waited < 3 * VN) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 3 * VN) check("ready_timeout", waited, 0);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.mask_wen     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int waited;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.mask_wen     = 1'b0;
        bus.mask_addr    = '0;
        bus.mask_din     = '0;
        #1;
        rst = 1'b1;

        // Reset state, then every mask reads back as zero.
        do_reset();
        check("t1_dout", bus.dout, 0);
        check("t1_dout_valid", bus.dout_valid, 0);
        check("t1_node_idx", bus.node_idx, 0);
        check("t1_sample_count", bus.sample_count, 0);
        check("t1_sample_ready", bus.sample_ready, 1);
        send_sample(5);
        idle(VN + 2);
        for (int k = 0; k < VN; k++) check("t1_zero_mask", obs_dout[k], 0);

        // Unity masks pass the sample through on every node.
        for (int k = 0; k < VN; k++) write_mask(k, 16384);
        send_sample(100);
        idle(VN + 2);
        for (int k = 0; k < VN; k++) check("t2_unity", obs_dout[k], 100);
        check("t2_count", bus.sample_count, 2);

        // Negative/half masks and floor behaviour.
        write_mask(3, -8192);
        write_mask(4, 8192);
        send_sample(-1);
        idle(VN + 2);
        check("t3_node3_neg1", obs_dout[3], 0);
        check("t3_node4_neg1", obs_dout[4], -1);
        send_sample(100);
        idle(VN + 2);
        check("t3_node3_100", obs_dout[3], -50);
        check("t3_node4_100", obs_dout[4], 50);

        // Saturation at both ends; out-of-range mask address ignored.
        write_mask(0, 32767);
        write_mask(12, 1);
        send_sample(64'sh7FFF_FFFF);
        idle(VN + 2);
        check("t4_sat_pos", obs_dout[0], 64'sd2147483647);
        send_sample(-64'sd2147483648);
        idle(VN + 2);
        check("t4_sat_neg", obs_dout[0], -64'sd2147483648);

        // Three samples back-to-back stream without a gap.
        do_reset();
        for (int k = 0; k < VN; k++) write_mask(k, 4096 * (k + 1));
        send_sample(11);
        send_sample(-22);
        send_sample(33);
        idle(VN + 3);
        check("t5_run_length", longest_run, 3 * VN);
        check("t5_count", bus.sample_count, 3);

        // Reset in the middle of a sample clears everything at once.
        send_sample(7);
        drive(0, 0, 0, 0, 0);
        waited = 0;
        while (!(bus.dout_valid && bus.node_idx == NIW'(4)) && waited < 3 * VN) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reach_node4", waited < 3 * VN, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_dout_valid", bus.dout_valid, 0);
        check("t6_async_node_idx", bus.node_idx, 0);
        check("t6_async_count", bus.sample_count, 0);
        check("t6_async_ready", bus.sample_ready, 1);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        send_sample(9);
        drive(0, 0, 0, 0, 0);
        waited = 0;
        while (!bus.dout_valid && waited < 3 * VN) begin
            @(negedge clk);
            waited++;
        end
        check("t6_restart_node", bus.node_idx, 0);
        check("t6_restart_dout", bus.dout, 0);
        idle(VN + 2);

        // Random traffic: valid toggling, mask writes in any state, wild addresses.
        for (int c = 0; c < 3000; c++) begin
            longint d;
            case ($urandom % 3)
                0:       d = longint'($urandom);
                1:       d = longint'($urandom_range(2000)) - 1000;
                default: d = ($urandom % 2) ? 64'sh7FFF_FFFF : -64'sd2147483648;
            endcase
            drive(($urandom % 4) != 0, d, ($urandom % 6) == 0,
                  int'($urandom % 16), longint'($urandom % 65536));
        end
        idle(VN + 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
